// File: rtl/nand3_bist_ctrl.sv
// Exhaustive self-test sequencer for one NAND3 cell: sweeps all eight
// input vectors, samples the cell output and tallies mismatches.
module nand3_bist_ctrl #(
   parameter int SETTLE_CYC = 2,
   parameter int PASSES     = 1,
   parameter int ERRW       = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic            dut_out,
   output logic [2:0]      dut_in,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [ERRW-1:0] err_cnt,
   output logic            fail_valid,
   output logic [2:0]      fail_vec
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam logic [3:0] RELOAD    = 4'(SETTLE_CYC - 1);
   localparam logic [7:0] LAST_PASS = 8'(PASSES - 1);

   state_t     state;
   logic [3:0] cnt;
   logic [7:0] pcnt;
   logic       mismatch;

   assign mismatch = dut_out ^ ~&dut_in;
   assign busy     = (state == SETTLE) || (state == SAMPLE);
   assign pass     = done && (err_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         dut_in     <= 3'b000;
         done       <= 1'b0;
         err_cnt    <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= 3'b000;
         cnt        <= 4'd0;
         pcnt       <= 8'd0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               // abort outranks start; a held start re-arms straight out of DONE
               if (start && !abort) begin
                  state      <= SETTLE;
                  dut_in     <= 3'b000;
                  err_cnt    <= '0;
                  fail_valid <= 1'b0;
                  fail_vec   <= 3'b000;
                  done       <= 1'b0;
                  pcnt       <= 8'd0;
                  cnt        <= RELOAD;
               end
            end
            SETTLE: begin
               if (abort) begin
                  state  <= IDLE;
                  dut_in <= 3'b000;
               end else if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               if (abort) begin
                  state  <= IDLE;
                  dut_in <= 3'b000;
               end else begin
                  if (mismatch) begin
                     if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                     if (!fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= dut_in;
                     end
                  end
                  if (dut_in != 3'b111) begin
                     dut_in <= dut_in + 3'd1;
                     cnt    <= RELOAD;
                     state  <= SETTLE;
                  end else if (pcnt != LAST_PASS) begin
                     pcnt   <= pcnt + 8'd1;
                     dut_in <= 3'b000;
                     cnt    <= RELOAD;
                     state  <= SETTLE;
                  end else begin
                     dut_in <= 3'b000;
                     done   <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nand3_bist_ctrl.sv
// Bench for nand3_bist_ctrl: two instances (default and a short multi-pass
// narrow-counter build) driven by random cell truth tables.
module tb_nand3_bist_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       st[2];
   logic       ab[2];
   logic       dout[2];
   logic [2:0] din[2];
   logic [2:0] fvec[2];
   logic       busy[2];
   logic       done[2];
   logic       pass[2];
   logic       fval[2];
   logic [3:0] err0;
   logic [1:0] err1;
   logic [7:0] tblr[2];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // the emulated cell: bit v of the table is its output for input v
   always_comb begin
      dout[0] = tblr[0][din[0]];
      dout[1] = tblr[1][din[1]];
   end

   nand3_bist_ctrl u0 (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]),
      .dut_out(dout[0]), .dut_in(din[0]), .busy(busy[0]),
      .done(done[0]), .pass(pass[0]), .err_cnt(err0),
      .fail_valid(fval[0]), .fail_vec(fvec[0])
   );

   nand3_bist_ctrl #(.SETTLE_CYC(1), .PASSES(2), .ERRW(2)) u1 (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]),
      .dut_out(dout[1]), .dut_in(din[1]), .busy(busy[1]),
      .done(done[1]), .pass(pass[1]), .err_cnt(err1),
      .fail_valid(fval[1]), .fail_vec(fvec[1])
   );

   function automatic int sc(input int u);
      return (u == 0) ? 2 : 1;
   endfunction

   function automatic int pc(input int u);
      return (u == 0) ? 1 : 2;
   endfunction

   function automatic int wc(input int u);
      return (u == 0) ? 4 : 2;
   endfunction

   function automatic logic [3:0] get_err(input int u);
      return (u == 0) ? err0 : {2'b00, err1};
   endfunction

   // Expected results of all samples taken before busy cycle ncyc.
   function automatic void model(input int u, input logic [7:0] tbl,
                                 input int ncyc, output int e,
                                 output bit fv, output logic [2:0] vec);
      e = 0;
      fv = 0;
      vec = 3'b000;
      for (int p = 0; p < pc(u); p++) begin
         for (int v = 0; v < 8; v++) begin
            int  c;
            bit  nand_v;
            logic [2:0] v3;
            v3 = 3'(v);
            nand_v = (v3 != 3'b111);
            c = (p * 8 + v) * (sc(u) + 1) + sc(u);
            if (c < ncyc && tbl[v] != nand_v) begin
               e++;
               if (!fv) begin
                  fv = 1;
                  vec = v3;
               end
            end
         end
      end
      if (e > (1 << wc(u)) - 1) e = (1 << wc(u)) - 1;
   endfunction

   task automatic run(input int u, input logic [7:0] tbl, input bit noisy);
      int n, e;
      bit fv;
      logic [2:0] fvv;
      n = 8 * pc(u) * (sc(u) + 1);
      model(u, tbl, 1 << 30, e, fv, fvv);
      tblr[u] = tbl;
      @(negedge clk); st[u] = 1'b1;
      @(negedge clk); st[u] = 1'b0;
      tests++;
      if (done[u] !== 1'b0 || get_err(u) !== 4'd0 || fval[u] !== 1'b0) begin
         fails++;
         $display("FAIL run_entry u=%0d: done=%b err=%0d fv=%b want 0 0 0",
                  u, done[u], get_err(u), fval[u]);
      end
      for (int k = 0; k < n; k++) begin
         tests++;
         if (busy[u] !== 1'b1 || din[u] !== 3'(k / (sc(u) + 1))) begin
            fails++;
            $display("FAIL run_seq u=%0d k=%0d: busy=%b din=%0d want 1 %0d",
                     u, k, busy[u], din[u], 3'(k / (sc(u) + 1)));
         end
         if (noisy) st[u] = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      st[u] = 1'b0;
      tests++;
      if (busy[u] !== 1'b0 || done[u] !== 1'b1 || din[u] !== 3'b000) begin
         fails++;
         $display("FAIL run_end u=%0d: busy=%b done=%b din=%0d want 0 1 0",
                  u, busy[u], done[u], din[u]);
      end
      tests++;
      if (get_err(u) !== 4'(e) || pass[u] !== (e == 0)) begin
         fails++;
         $display("FAIL run_err u=%0d tbl=%h: err=%0d pass=%b want %0d %b",
                  u, tbl, get_err(u), pass[u], e, (e == 0));
      end
      tests++;
      if (fval[u] !== fv || fvec[u] !== fvv) begin
         fails++;
         $display("FAIL run_fail u=%0d tbl=%h: fv=%b vec=%0d want %b %0d",
                  u, tbl, fval[u], fvec[u], fv, fvv);
      end
   endtask

   task automatic test_reset();
      #1;
      for (int u = 0; u < 2; u++) begin
         tests++;
         if (busy[u] !== 1'b0 || done[u] !== 1'b0 || pass[u] !== 1'b0 ||
             din[u] !== 3'b000 || get_err(u) !== 4'd0 ||
             fval[u] !== 1'b0 || fvec[u] !== 3'b000) begin
            fails++;
            $display("FAIL reset u=%0d: busy=%b done=%b pass=%b din=%0d err=%0d fv=%b vec=%0d want all 0",
                     u, busy[u], done[u], pass[u], din[u], get_err(u),
                     fval[u], fvec[u]);
         end
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if (busy[0] !== 1'b0 || done[0] !== 1'b0 || din[0] !== 3'b000) begin
         fails++;
         $display("FAIL reset_idle: busy=%b done=%b din=%0d want 0 0 0",
                  busy[0], done[0], din[0]);
      end
   endtask

   task automatic test_golden();
      run(0, 8'h7F, 1'b0);
   endtask

   task automatic test_stuck();
      run(1, 8'hFF, 1'b0);
      run(1, 8'h00, 1'b0);
   endtask

   task automatic abort_at(input int u, input logic [7:0] tbl, input int kab);
      int e;
      bit fv;
      logic [2:0] fvv;
      model(u, tbl, kab, e, fv, fvv);
      tblr[u] = tbl;
      @(negedge clk); st[u] = 1'b1;
      @(negedge clk); st[u] = 1'b0;
      for (int k = 0; k < kab; k++) @(negedge clk);
      ab[u] = 1'b1;
      @(negedge clk); ab[u] = 1'b0;
      tests++;
      if (busy[u] !== 1'b0 || done[u] !== 1'b0 || din[u] !== 3'b000) begin
         fails++;
         $display("FAIL abort_state u=%0d k=%0d: busy=%b done=%b din=%0d want 0 0 0",
                  u, kab, busy[u], done[u], din[u]);
      end
      // abort beats start while idle, and results stay frozen
      st[u] = 1'b1; ab[u] = 1'b1;
      repeat (3) @(negedge clk);
      st[u] = 1'b0; ab[u] = 1'b0;
      tests++;
      if (busy[u] !== 1'b0 || get_err(u) !== 4'(e) ||
          fval[u] !== fv || fvec[u] !== fvv) begin
         fails++;
         $display("FAIL abort_hold u=%0d k=%0d: busy=%b err=%0d fv=%b vec=%0d want 0 %0d %b %0d",
                  u, kab, busy[u], get_err(u), fval[u], fvec[u], e, fv, fvv);
      end
      run(u, 8'($urandom), 1'b0);
   endtask

   task automatic test_abort();
      abort_at(0, 8'($urandom), 9);
      abort_at(1, 8'hFF, 31);
   endtask

   task automatic test_reset_mid();
      tblr[0] = 8'h00;
      @(negedge clk); st[0] = 1'b1;
      @(negedge clk); st[0] = 1'b0;
      for (int k = 0; k < 15; k++) @(negedge clk);
      tests++;
      if (din[0] !== 3'd5 || err0 !== 4'd5) begin
         fails++;
         $display("FAIL mid_pre: din=%0d err=%0d want 5 5", din[0], err0);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if (busy[0] !== 1'b0 || done[0] !== 1'b0 || din[0] !== 3'b000 ||
          err0 !== 4'd0 || fval[0] !== 1'b0 || fvec[0] !== 3'b000) begin
         fails++;
         $display("FAIL mid_reset: busy=%b done=%b din=%0d err=%0d fv=%b vec=%0d want all 0",
                  busy[0], done[0], din[0], err0, fval[0], fvec[0]);
      end
      @(negedge clk); rst_n = 1'b1;
      run(0, 8'h7F, 1'b0);
   endtask

   task automatic test_back_to_back();
      int count;
      run(0, 8'h7F, 1'b1);
      st[0] = 1'b1;
      @(negedge clk);
      tests++;
      if (busy[0] !== 1'b1 || done[0] !== 1'b0 || din[0] !== 3'b000) begin
         fails++;
         $display("FAIL b2b_restart: busy=%b done=%b din=%0d want 1 0 0",
                  busy[0], done[0], din[0]);
      end
      count = 0;
      while (done[0] !== 1'b1 && count < 200) begin
         @(negedge clk);
         count++;
         if (count == 5) st[0] = 1'b0;
      end
      st[0] = 1'b0;
      tests++;
      if (count !== 24 || pass[0] !== 1'b1) begin
         fails++;
         $display("FAIL b2b_len: cycles=%0d pass=%b want 24 1", count, pass[0]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) run(i % 2, 8'($urandom), 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         st[u] = 1'b0;
         ab[u] = 1'b0;
         tblr[u] = 8'h7F;
      end
      repeat (2) @(negedge clk);
      test_reset();
      test_golden();
      test_stuck();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
